instr_loader: RTL and testbench
===============================

Name: instr_loader

Overview:
- Write-side counterpart of the instruction ROM: streams a program image, byte by byte, into the byte-addressed instruction memory starting at the reset vector.
- Accepts bytes over a valid/ready handshake and assembles them little-endian into 32-bit words.
- Issues one byte-enabled word write per assembled word.
- Sits between the host/testbench boot path and the instruction memory write port; busy holds the core in stall while loading.

Parameters:
- A_WIDTH, 32, address width of the instruction memory.
- BASE_ADDR, 32'hBFC00000, first byte address written (word-aligned).
- MEM_BYTES, 4096, capacity of instruction memory in bytes.
- LEN_WIDTH, 13, width of the length input; must hold MEM_BYTES+1.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset.
- start  input  1  one-cycle pulse; begins a load of length bytes.
- length  input  LEN_WIDTH  byte count of image; sampled only when start is accepted.
- s_data  input  8  incoming program byte.
- s_valid  input  1  s_data valid.
- s_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  word write strobe to instruction memory.
- mem_addr  output  A_WIDTH  word-aligned byte address of the write.
- mem_wdata  output  32  assembled word, byte0 in bits [7:0].
- mem_be  output  4  byte enables, bit i enables mem_wdata[8i+7:8i].
- busy  output  1  load in progress (FILL or WRITE).
- done  output  1  last load completed.
- error  output  1  last start had length > MEM_BYTES.

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous, active-high.
- Reset values: all outputs 0; state IDLE; counters and word buffer cleared.
- Reset mid-load aborts immediately. No write is emitted and the partial buffer is discarded.
- States: IDLE, FILL, WRITE, DONE, ERR.
- start is accepted in IDLE, DONE or ERR, and ignored in FILL/WRITE.
- On an accepted start:
  - length latched; byte count cnt=0; word address = BASE_ADDR; buffer and be cleared.
  - length==0 -> DONE next cycle, no write.
  - length > MEM_BYTES -> ERR next cycle.
  - otherwise -> FILL.
- FILL:
  - s_ready=1.
  - Transfer occurs when s_valid && s_ready. s_data goes to lane cnt[1:0], the matching be bit is set, cnt increments.
  - If the lane was 3, or cnt+1 == length, next state is WRITE.
  - s_valid low simply stalls; no timeout.
- WRITE:
  - s_ready=0; mem_we=1 for exactly this one cycle.
  - mem_addr = current word address; mem_wdata = buffer (unfilled lanes 0); mem_be = accumulated enables.
  - Next cycle: word address += 4, buffer and be cleared. If cnt == length -> DONE, else -> FILL.
- Outputs outside WRITE: mem_we=0 and mem_be=0.
- busy=1 exactly in FILL and WRITE.
- DONE: done=1, held until the next accepted start; done drops in the cycle after start.
- ERR: error=1, sticky until reset or the next accepted start. No memory writes, s_ready=0.
- Throughput: a full word costs 4 accepted-byte cycles + 1 write cycle. s_ready is low during WRITE, so no byte is lost.
- Address arithmetic:
  - Last write address is BASE_ADDR + 4*floor((length-1)/4).
  - length==MEM_BYTES ends at BASE_ADDR+MEM_BYTES-4; never exceeds the array.
- Final partial word: be = 0001/0011/0111 for 1/2/3 residual bytes.

Test Plan:
- start, length=8; bytes 13 05 10 00 93 05 20 00 -> mem_we at BFC00000 wdata 00100513 be 1111, then BFC00004 wdata 00200593 be 1111; done=1; busy low after.
- length=6; bytes 01..06 -> writes 04030201 be 1111 at BFC00000 and 00000605 be 0011 at BFC00004; exactly 2 mem_we pulses.
- length=0 -> done=1 the next cycle; no mem_we; s_ready never 1.
- length=4097 -> error=1; s_ready stays 0 with s_valid held high. A following start with length=4 clears error and loads normally.
- length=4 with s_valid toggling every other cycle, plus start pulsed mid-load -> only 4 bytes accepted; single write 0xDDCCBBAA for bytes AA BB CC DD; second start ignored.
- Assert rst after 2 of 4 bytes -> outputs 0 asynchronously, no mem_we. A new load of length=4 then writes at BFC00000 with only the new bytes.

Source files
------------

// File: rtl/instr_loader_if.sv
// Boot-path bundle between the host byte stream, the loader and the instruction memory write port.
// The master modport drives bytes and commands in; the slave modport is the loader itself.
interface instr_loader_if #(
    parameter int A_WIDTH   = 32,
    parameter int LEN_WIDTH = 13
);
    logic                 start;
    logic [LEN_WIDTH-1:0] length;
    logic [7:0]           s_data;
    logic                 s_valid;
    logic                 s_ready;
    logic                 mem_we;
    logic [A_WIDTH-1:0]   mem_addr;
    logic [31:0]          mem_wdata;
    logic [3:0]           mem_be;
    logic                 busy;
    logic                 done;
    logic                 error;

    modport master (
        output start, length, s_data, s_valid,
        input  s_ready, mem_we, mem_addr, mem_wdata, mem_be, busy, done, error
    );

    modport slave (
        input  start, length, s_data, s_valid,
        output s_ready, mem_we, mem_addr, mem_wdata, mem_be, busy, done, error
    );
endinterface

// File: rtl/instr_loader.sv
// Streams a program image byte by byte into instruction memory from BASE_ADDR upward,
// packing bytes little-endian into words and issuing one byte-enabled write per word.
module instr_loader #(
    parameter int                 A_WIDTH   = 32,
    parameter logic [A_WIDTH-1:0] BASE_ADDR = A_WIDTH'(32'hBFC00000),
    parameter int                 MEM_BYTES = 4096,
    parameter int                 LEN_WIDTH = 13
) (
    input  logic         clk,
    input  logic         rst,
    instr_loader_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        FILL,
        WRITE,
        DONE,
        ERR
    } state_t;

    localparam logic [LEN_WIDTH-1:0] MEM_LIMIT = LEN_WIDTH'(MEM_BYTES);

    state_t               state;
    state_t               state_next;
    logic [LEN_WIDTH-1:0] len_q;
    logic [LEN_WIDTH-1:0] cnt;
    logic [A_WIDTH-1:0]   addr_q;
    logic [31:0]          buf_q;
    logic [3:0]           be_q;
    logic                 start_ok;
    logic                 take;

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        state_next    = state;
        start_ok      = 1'b0;
        take          = 1'b0;
        bus.s_ready   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_be    = '0;
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        bus.error     = 1'b0;

        case (state)
            IDLE, DONE, ERR: begin
                bus.done  = (state == DONE);
                bus.error = (state == ERR);
                if (bus.start) begin
                    start_ok = 1'b1;
                    if (bus.length == '0)
                        state_next = DONE;
                    else if (bus.length > MEM_LIMIT)
                        state_next = ERR;
                    else
                        state_next = FILL;
                end
            end
            FILL: begin
                bus.s_ready = 1'b1;
                bus.busy    = 1'b1;
                take        = bus.s_valid;
                // A word is flushed when its top lane fills or the image runs out.
                if (take && ((cnt[1:0] == 2'd3) || ((cnt + LEN_WIDTH'(1)) == len_q)))
                    state_next = WRITE;
            end
            WRITE: begin
                bus.busy      = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = addr_q;
                bus.mem_wdata = buf_q;
                bus.mem_be    = be_q;
                state_next    = (cnt == len_q) ? DONE : FILL;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            len_q  <= '0;
            cnt    <= '0;
            addr_q <= '0;
            buf_q  <= '0;
            be_q   <= '0;
        end else begin
            state <= state_next;
            if (start_ok) begin
                len_q  <= bus.length;
                cnt    <= '0;
                addr_q <= BASE_ADDR;
                buf_q  <= '0;
                be_q   <= '0;
            end else if (take) begin
                buf_q[{cnt[1:0], 3'b000} +: 8] <= bus.s_data;
                be_q[cnt[1:0]]                 <= 1'b1;
                cnt                            <= cnt + LEN_WIDTH'(1);
            end else if (state == WRITE) begin
                addr_q <= addr_q + A_WIDTH'(4);
                buf_q  <= '0;
                be_q   <= '0;
            end
        end
    end
endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: drives byte streams, captures memory writes and
// compares them against hand-computed words, addresses and byte enables.
module tb_instr_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    logic [3:0]  wr_be[$];
    logic        ready_seen;

    instr_loader_if #(.A_WIDTH(32), .LEN_WIDTH(13)) bus ();

    instr_loader #(
        .A_WIDTH  (32),
        .BASE_ADDR(32'hBFC00000),
        .MEM_BYTES(4096),
        .LEN_WIDTH(13)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Outputs depend only on registered state, so the falling edge is a stable sample point.
    always @(negedge clk) begin
        if (bus.mem_we) begin
            wr_addr.push_back(bus.mem_addr);
            wr_data.push_back(bus.mem_wdata);
            wr_be.push_back(bus.mem_be);
        end
        if (bus.s_ready) ready_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_be.delete();
        ready_seen = 1'b0;
    endtask

    task automatic do_start(input logic [12:0] len);
        bus.start  = 1'b1;
        bus.length = len;
        @(negedge clk);
        bus.start  = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.s_data  = b;
        bus.s_valid = 1'b1;
        while (!bus.s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("ready_timeout", 0, 1);
        @(negedge clk);
        bus.s_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!bus.done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, bus.done, 1);
    endtask

    task automatic check_write(input string tag, input int idx, input logic [31:0] addr,
                               input logic [31:0] data, input logic [3:0] be);
        if (idx >= wr_addr.size()) begin
            check({tag, "_missing"}, wr_addr.size(), idx + 1);
        end else begin
            check({tag, "_addr"}, wr_addr[idx], addr);
            check({tag, "_data"}, wr_data[idx], data);
            check({tag, "_be"}, wr_be[idx], be);
        end
    endtask

    initial begin
        logic [7:0] img8[8];
        bus.start   = 1'b0;
        bus.length  = '0;
        bus.s_data  = '0;
        bus.s_valid = 1'b0;
        clear_log();

        // Reset state
        #12;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_error", bus.error, 0);
        check("rst_ready", bus.s_ready, 0);
        check("rst_we", bus.mem_we, 0);
        check("rst_be", bus.mem_be, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Two full words
        img8 = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
        clear_log();
        do_start(13'd8);
        check("t1_busy", bus.busy, 1);
        foreach (img8[i]) send_byte(img8[i]);
        wait_done("t1_done", 20);
        check("t1_nwr", wr_addr.size(), 2);
        check_write("t1_w0", 0, 32'hBFC00000, 32'h00100513, 4'b1111);
        check_write("t1_w1", 1, 32'hBFC00004, 32'h00200593, 4'b1111);
        check("t1_busy_after", bus.busy, 0);

        // Partial final word; done drops in the cycle after start
        clear_log();
        do_start(13'd6);
        check("t2_done_drop", bus.done, 0);
        for (int i = 1; i <= 6; i++) send_byte(8'(i));
        wait_done("t2_done", 20);
        check("t2_nwr", wr_addr.size(), 2);
        check_write("t2_w0", 0, 32'hBFC00000, 32'h04030201, 4'b1111);
        check_write("t2_w1", 1, 32'hBFC00004, 32'h00000605, 4'b0011);

        // Oversize length -> error; s_ready stays low under a held s_valid
        clear_log();
        do_start(13'd4097);
        check("t3_error", bus.error, 1);
        check("t3_done", bus.done, 0);
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h5A;
        repeat (5) @(negedge clk);
        check("t3_error_sticky", bus.error, 1);
        check("t3_ready_never", ready_seen, 0);
        check("t3_nwr", wr_addr.size(), 0);
        bus.s_valid = 1'b0;
        do_start(13'd4);
        check("t3_error_clr", bus.error, 0);
        foreach (img8[i]) if (i < 4) send_byte(8'h11 * 8'(i + 1));
        wait_done("t3_reload_done", 20);
        check("t3_reload_nwr", wr_addr.size(), 1);
        check_write("t3_reload", 0, 32'hBFC00000, 32'h44332211, 4'b1111);

        // Toggling s_valid and a start mid-load that must be ignored
        clear_log();
        do_start(13'd4);
        send_byte(8'hAA);
        @(negedge clk);
        send_byte(8'hBB);
        bus.start  = 1'b1;
        bus.length = 13'd8;
        @(negedge clk);
        bus.start  = 1'b0;
        send_byte(8'hCC);
        @(negedge clk);
        send_byte(8'hDD);
        wait_done("t4_done", 20);
        ready_seen  = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'hEE;
        repeat (4) @(negedge clk);
        bus.s_valid = 1'b0;
        check("t4_nwr", wr_addr.size(), 1);
        check_write("t4_w0", 0, 32'hBFC00000, 32'hDDCCBBAA, 4'b1111);
        check("t4_no_extra_ready", ready_seen, 0);

        // Asynchronous reset mid-load, then a clean reload
        clear_log();
        do_start(13'd4);
        send_byte(8'h01);
        send_byte(8'h02);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_busy", bus.busy, 0);
        check("t5_rst_ready", bus.s_ready, 0);
        check("t5_rst_done", bus.done, 0);
        check("t5_rst_we", bus.mem_we, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t5_nwr_abort", wr_addr.size(), 0);
        do_start(13'd4);
        send_byte(8'h55);
        send_byte(8'h66);
        send_byte(8'h77);
        send_byte(8'h88);
        wait_done("t5_done", 20);
        check("t5_nwr", wr_addr.size(), 1);
        check_write("t5_w0", 0, 32'hBFC00000, 32'h88776655, 4'b1111);

        // Zero length after an error: done next cycle, no write, no ready
        do_start(13'd5000);
        check("t6_error", bus.error, 1);
        clear_log();
        do_start(13'd0);
        check("t6_done", bus.done, 1);
        check("t6_error_clr", bus.error, 0);
        check("t6_busy", bus.busy, 0);
        repeat (3) @(negedge clk);
        check("t6_nwr", wr_addr.size(), 0);
        check("t6_ready_never", ready_seen, 0);

        // Full-capacity image ends exactly at the last word of the array
        clear_log();
        do_start(13'd4096);
        for (int i = 0; i < 4096; i++) send_byte(8'(i));
        wait_done("t7_done", 20);
        check("t7_nwr", wr_addr.size(), 1024);
        check_write("t7_first", 0, 32'hBFC00000, 32'h03020100, 4'b1111);
        check_write("t7_last", 1023, 32'hBFC00FFC, 32'hFFFEFDFC, 4'b1111);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
